// File: rtl/lfsr_encrypter.sv
// Pads a plaintext message with a preamble byte into a 64-byte frame, XORs it with a 5-bit LFSR and writes it back to memory.
// Latency 2 cycles per byte (read, then write); no backpressure, the memory port is assumed always ready.
module lfsr_encrypter #(
    parameter int FRAME_LEN = 64,
    parameter int MSG_MAX   = 50,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 64
) (
    input  logic       clk,
    input  logic       init,
    input  logic [7:0] preamble,
    input  logic [7:0] pre_len,
    input  logic [7:0] msg_len,
    input  logic [2:0] pat_sel,
    input  logic [4:0] lfsr_init,
    output logic [7:0] mem_raddr,
    input  logic [7:0] mem_rdata,
    output logic       mem_wr_en,
    output logic [7:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [7:0] SRC_B    = 8'(SRC_BASE);
    localparam logic [7:0] DST_B    = 8'(DST_BASE);
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [7:0] MSG_CAP  = 8'(MSG_MAX);

    state_t     state, state_nxt;
    logic [7:0] idx;
    logic [4:0] lfsr;
    logic [7:0] pad_q, pre_q, len_q;
    logic [4:0] taps_q;

    logic [7:0] pre_c, len_c;
    logic [2:0] sel_c;
    logic [4:0] taps_c, seed_c;
    logic [4:0] lfsr_step;
    logic [8:0] msg_end;
    logic       in_msg;
    logic [7:0] msg_off;
    logic [7:0] plain;

    // Out-of-range configuration is clamped rather than rejected.
    always_comb begin
        pre_c  = pre_len;
        if (pre_len < 8'd7)
            pre_c = 8'd7;
        else if (pre_len > 8'd12)
            pre_c = 8'd12;
        len_c  = (msg_len > MSG_CAP) ? MSG_CAP : msg_len;
        sel_c  = (pat_sel > 3'd5) ? 3'd3 : pat_sel;
        seed_c = (lfsr_init == 5'd0) ? 5'd1 : lfsr_init;
        case (sel_c)
            3'd0:    taps_c = 5'h1E;
            3'd1:    taps_c = 5'h1D;
            3'd2:    taps_c = 5'h1B;
            3'd3:    taps_c = 5'h17;
            3'd4:    taps_c = 5'h14;
            default: taps_c = 5'h12;
        endcase
    end

    assign lfsr_step = {lfsr[3:0], 1'b0} + {4'b0000, ^(lfsr & taps_q)};
    assign msg_end   = {1'b0, pre_q} + {1'b0, len_q};
    assign in_msg    = (idx >= pre_q) && ({1'b0, idx} < msg_end);
    assign msg_off   = idx - pre_q;
    assign plain     = in_msg ? mem_rdata : pad_q;

    always_ff @(posedge clk or posedge init) begin
        if (init)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            idx    <= 8'd0;
            lfsr   <= 5'd0;
            pad_q  <= 8'd0;
            pre_q  <= 8'd0;
            len_q  <= 8'd0;
            taps_q <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    idx    <= 8'd0;
                    lfsr   <= seed_c;
                    pad_q  <= preamble;
                    pre_q  <= pre_c;
                    len_q  <= len_c;
                    taps_q <= taps_c;
                end
                WR: begin
                    if (idx != LAST_IDX) begin
                        idx  <= idx + 8'd1;
                        lfsr <= lfsr_step;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        mem_raddr = 8'd0;
        mem_wr_en = 1'b0;
        mem_waddr = 8'd0;
        mem_wdata = 8'd0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: state_nxt = RD;
            RD: begin
                busy      = 1'b1;
                mem_raddr = in_msg ? (SRC_B + msg_off) : SRC_B;
                state_nxt = WR;
            end
            WR: begin
                busy      = 1'b1;
                mem_wr_en = 1'b1;
                mem_waddr = DST_B + idx;
                mem_wdata = plain ^ {3'b000, lfsr};
                state_nxt = (idx == LAST_IDX) ? DONE : RD;
            end
            DONE: done = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lfsr_encrypter.sv
// Scoreboard bench for lfsr_encrypter: stimulus pushes expected writes, a negedge monitor pops and compares them.
module tb_lfsr_encrypter;
    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic [7:0] preamble = 8'h00;
    logic [7:0] pre_len = 8'd0;
    logic [7:0] msg_len = 8'd0;
    logic [2:0] pat_sel = 3'd0;
    logic [4:0] lfsr_init = 5'd0;
    logic [7:0] mem_raddr;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_wr_en;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [0:255];
    logic [7:0]  nom [0:63];
    logic [7:0]  src_snap [0:63];
    logic [15:0] exp_q [$];
    string       msg = "Hey_Hamm_Look_Im_Picasso";

    lfsr_encrypter dut (
        .clk(clk), .init(init), .preamble(preamble), .pre_len(pre_len),
        .msg_len(msg_len), .pat_sel(pat_sel), .lfsr_init(lfsr_init),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_raddr];
        if (mem_wr_en)
            mem[mem_waddr] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_wr_en) begin
            logic [15:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%02h data=%02h (no write expected)", mem_waddr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_waddr, mem_wdata} !== e) begin
                    failures++;
                    $display("FAIL write got addr=%02h data=%02h required addr=%02h data=%02h",
                             mem_waddr, mem_wdata, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [4:0] taps_of(input logic [2:0] p);
        case (p)
            3'd0: return 5'h1E;
            3'd1: return 5'h1D;
            3'd2: return 5'h1B;
            3'd3: return 5'h17;
            3'd4: return 5'h14;
            default: return 5'h12;
        endcase
    endfunction

    function automatic logic [4:0] step(input logic [4:0] l, input logic [4:0] t);
        return {l[3:0], 1'b0} | {4'b0000, ^(l & t)};
    endfunction

    // Expected frame, given already-legal configuration values.
    task automatic push_frame(input logic [7:0] pb, input int pl, input int ml,
                              input logic [2:0] ps, input logic [4:0] seed);
        logic [4:0] l = seed;
        logic [7:0] p;
        for (int i = 0; i < 64; i++) begin
            p = (i < pl || i >= pl + ml) ? pb : mem[i - pl];
            exp_q.push_back({8'(64 + i), p ^ {3'b000, l}});
            l = step(l, taps_of(ps));
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < 256; i++) mem[i] = (i < 64) ? 8'(8'hA0 + i) : 8'h00;
        for (int i = 0; i < msg.len(); i++) mem[i] = msg[i];
    endtask

    task automatic start(input logic [7:0] pb, input logic [7:0] pl, input logic [7:0] ml,
                         input logic [2:0] ps, input logic [4:0] seed);
        @(negedge clk);
        init = 1'b1;
        preamble = pb; pre_len = pl; msg_len = ml; pat_sel = ps; lfsr_init = seed;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic wait_done(input int change_at, output int done_edge);
        done_edge = -1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk);
            #1;
            if (e == change_at) begin
                pat_sel = 3'd5;
                lfsr_init = 5'h1F;
            end
            if (done) begin
                done_edge = e;
                break;
            end
        end
    endtask

    task automatic compare_nom(input string name);
        int bad = 0;
        for (int i = 0; i < 64; i++) if (mem[64 + i] !== nom[i]) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        int de;
        int bad;
        logic [4:0] l;
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int de;
        int bad;
        logic [4:0] l;

        // Reset state
        load_mem();
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_raddr", mem_raddr, 0);
        check("rst_wdata", mem_wdata, 0);

        // Nominal
        push_frame(8'h7E, 9, 24, 3'd2, 5'h01);
        start(8'h7E, 8'd9, 8'd24, 3'd2, 5'h01);
        wait_done(0, de);
        check("nom_done_edge", de, 129);
        @(negedge clk);
        check("nom_m64", mem[64], 8'h7F);
        check("nom_m65", mem[65], 8'h7D);
        check("nom_m66", mem[66], 8'h78);
        check("nom_m72", mem[72], 8'h77);
        check("nom_m73", mem[73], 8'h5A);
        check("nom_queue_left", exp_q.size(), 0);
        bad = 0;
        l = 5'h01;
        for (int i = 0; i < 64; i++) begin
            if (i >= 9 && i < 33 && (mem[64 + i] ^ {3'b000, l}) !== msg[i - 9]) bad++;
            l = step(l, 5'h1B);
        end
        check("nom_round_trip", bad, 0);
        for (int i = 0; i < 64; i++) nom[i] = mem[64 + i];
        repeat (5) @(negedge clk);
        check("nom_done_held", done, 1);
        check("nom_busy_after", busy, 0);

        // Clamping
        load_mem();
        push_frame(8'h7E, 7, 50, 3'd3, 5'h01);
        start(8'h7E, 8'd3, 8'd60, 3'd7, 5'h00);
        wait_done(0, de);
        check("clamp_done_edge", de, 129);
        @(negedge clk);
        check("clamp_m64", mem[64], 8'h7F);
        check("clamp_queue_left", exp_q.size(), 0);

        // Reset mid-run during WR of idx 20, then rerun
        load_mem();
        push_frame(8'h7E, 9, 24, 3'd2, 5'h01);
        start(8'h7E, 8'd9, 8'd24, 3'd2, 5'h01);
        repeat (42) @(posedge clk);
        #2;
        init = 1'b1;
        #1;
        check("abort_wr_en", mem_wr_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pending", exp_q.size(), 44);
        exp_q.delete();
        repeat (3) @(posedge clk);
        push_frame(8'h7E, 9, 24, 3'd2, 5'h01);
        start(8'h7E, 8'd9, 8'd24, 3'd2, 5'h01);
        wait_done(0, de);
        check("rerun_done_edge", de, 129);
        @(negedge clk);
        compare_nom("rerun_frame");

        // Empty message; source region untouched
        load_mem();
        for (int i = 0; i < 64; i++) src_snap[i] = mem[i];
        push_frame(8'h5A, 10, 0, 3'd4, 5'h15);
        start(8'h5A, 8'd10, 8'd0, 3'd4, 5'h15);
        wait_done(0, de);
        check("empty_done_edge", de, 129);
        @(negedge clk);
        check("empty_m64", mem[64], 8'h5A ^ 8'h15);
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== src_snap[i]) bad++;
        check("empty_src_kept", bad, 0);

        // Configuration change after the latch edge is ignored
        load_mem();
        push_frame(8'h7E, 9, 24, 3'd2, 5'h01);
        start(8'h7E, 8'd9, 8'd24, 3'd2, 5'h01);
        wait_done(10, de);
        check("late_cfg_done_edge", de, 129);
        @(negedge clk);
        compare_nom("late_cfg_frame");
        check("late_cfg_queue_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
